ex_mem_elastic_reg: RTL and testbench
=====================================

EX_MEM_ELASTIC_REG -- requirements
Module: ex_mem_elastic_reg

Interface
REQ-001 SHALL have parameter DW, default 32, width of the data fields: alu_out, write_data and pc_plus_4.
REQ-002 SHALL have parameter REGW, default 5, width of the destination register index.
REQ-003 SHALL have parameter CTRLW, default 14, width of the packed control bundle {reg_write[13], wb_sel[12:11], mem_write[10], opcode[9:3], func3[2:0]}.
REQ-004 SHALL have these ports, clock and reset first:
  clk_i         in   1      clock; all state updates on the rising edge
  rst_i         in   1      reset, asynchronous, active-high
  flush_i       in   1      synchronous squash of all held entries
  valid_e_i     in   1      execute-stage payload valid
  ready_e_o     out  1      stage can accept a payload this cycle
  alu_out_e     in   DW     execute-stage ALU result
  write_data_e  in   DW     execute-stage store data
  rd_e          in   REGW   execute-stage destination register
  pc_plus_4_e   in   DW     execute-stage PC+4
  ctrl_e        in   CTRLW  execute-stage control bundle
  valid_m_o     out  1      memory-stage payload valid
  ready_m_i     in   1      memory stage consumes the payload this cycle
  alu_out_m, write_data_m, pc_plus_4_m  out  DW  memory-stage payload
  rd_m          out  REGW   memory-stage destination register
  ctrl_m        out  CTRLW  memory-stage control bundle
  occ_o         out  2      number of held entries, 0 to 2

Function
REQ-005 SHALL accept an entry when valid_e_i && ready_e_o at a rising edge.
REQ-006 SHALL deliver an entry when valid_m_o && ready_m_i at a rising edge.
REQ-007 SHALL present an accepted entry on the _m outputs after exactly 1 cycle if the output register was empty or draining in that cycle.
REQ-008 SHALL preserve entry order; no entry is dropped or duplicated unless flush_i is asserted.
REQ-009 SHALL hold a main register (output register) and a skid register, with three states: EMPTY (occ 0), ONE (occ 1, main valid), FULL (occ 2, main and skid valid).
REQ-010 EMPTY: on accept, go to ONE with main loaded from the input.
REQ-011 ONE with accept and deliver: stay in ONE and load main from the input.
REQ-012 ONE with accept and no deliver: go to FULL and load skid from the input.
REQ-013 ONE with deliver and no accept: go to EMPTY.
REQ-014 FULL with deliver: go to ONE and load main from skid; no accept is possible in FULL.
REQ-015 SHALL drive ready_e_o = (state != FULL), taken directly from a register with no combinational path from ready_m_i.
REQ-016 SHALL drive valid_m_o = (state != EMPTY), and occ_o SHALL equal the state's entry count.
REQ-017 SHALL hold the _m outputs stable while valid_m_o && !ready_m_i.
REQ-018 flush_i high at an edge SHALL force EMPTY.
REQ-019 flush_i SHALL override a simultaneous accept or deliver, so the input entry is discarded.
REQ-020 On flush, ctrl_m SHALL clear to 0 (bubble: reg_write=0, mem_write=0); data fields are don't-care.
REQ-021 When valid_m_o=0, ctrl_m SHALL read 0 so that a held stale entry never writes the register file or memory.

Reset
REQ-022 rst_i SHALL immediately force EMPTY, independent of clk_i.
REQ-023 During reset, valid_m_o=0, ready_e_o=1, occ_o=0, and all _m payload outputs and skid contents =0.
REQ-024 Reset asserted mid-transfer SHALL discard all held entries; the first edge after release behaves as EMPTY.

Configuration
REQ-025 Macro EX_MEM_SKID_EN, when defined, SHALL build the skid register and the 3-state behaviour of REQ-009 to REQ-015.
REQ-026 Without EX_MEM_SKID_EN, the design SHALL have no skid register.
REQ-027 Without EX_MEM_SKID_EN, the states SHALL be EMPTY and ONE only.
REQ-028 Without EX_MEM_SKID_EN, ready_e_o SHALL be combinational: ready_e_o = !valid_m_o || ready_m_i.
REQ-029 Without EX_MEM_SKID_EN, occ_o SHALL be at most 1; all other requirements hold unchanged.

Verification
REQ-030 Streaming: ready_m_i=1, valid_e_i=1 for 4 cycles, alu_out_e=0x10,0x20,0x30,0x40 -> valid_m_o high from cycle 2, alu_out_m=0x10..0x40 in consecutive cycles, occ_o=1 throughout.
REQ-031 Backpressure (skid build): entry 0xA accepted, ready_m_i=0, entry 0xB offered -> occ_o=2, ready_e_o=0 next cycle, alu_out_m holds 0xA; raise ready_m_i -> 0xA delivered then 0xB, ready_e_o=1 after the first delivery.
REQ-032 Flush in FULL with valid_e_i=1, rd_e=7 -> next cycle valid_m_o=0, ctrl_m=0, occ_o=0, and rd=7 is never delivered.
REQ-033 Async reset in FULL mid-cycle -> valid_m_o=0 and ready_e_o=1 before the next clock edge; after release, entry 0x55 is delivered one cycle after accept.
REQ-034 Non-skid build: ready_m_i toggling 1,0,1 with valid_e_i=1 -> ready_e_o follows !valid_m_o||ready_m_i in the same cycle, and no entry is lost.
REQ-035 Random valid/ready/flush with 10k entries against a scoreboard -> order preserved, no loss except entries in flight at flush, and ctrl_m=0 whenever valid_m_o=0.

Source files
------------

// File: rtl/ex_mem_elastic_reg.sv
// ex_mem_elastic_reg: EX/MEM pipeline register with valid/ready handshake; optional skid entry under EX_MEM_SKID_EN.
module ex_mem_elastic_reg #(
  parameter int DW    = 32,
  parameter int REGW  = 5,
  parameter int CTRLW = 14
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             valid_e_i,
  output logic             ready_e_o,
  input  logic [DW-1:0]    alu_out_e,
  input  logic [DW-1:0]    write_data_e,
  input  logic [REGW-1:0]  rd_e,
  input  logic [DW-1:0]    pc_plus_4_e,
  input  logic [CTRLW-1:0] ctrl_e,
  output logic             valid_m_o,
  input  logic             ready_m_i,
  output logic [DW-1:0]    alu_out_m,
  output logic [DW-1:0]    write_data_m,
  output logic [DW-1:0]    pc_plus_4_m,
  output logic [REGW-1:0]  rd_m,
  output logic [CTRLW-1:0] ctrl_m,
  output logic [1:0]       occ_o
);
  localparam int PW = 3*DW + REGW + CTRLW;
  logic [PW-1:0] in_p, main_q;
  logic valid, acc, dlv, ld_main;
  assign in_p = {alu_out_e, write_data_e, pc_plus_4_e, rd_e, ctrl_e};
  assign valid_m_o = valid;
  assign dlv = valid && ready_m_i;
  assign acc = valid_e_i && ready_e_o;
  assign {alu_out_m, write_data_m, pc_plus_4_m, rd_m} = main_q[PW-1:CTRLW];
  // a stale held entry must never look like a live write
  assign ctrl_m = valid ? main_q[CTRLW-1:0] : '0;
`ifdef EX_MEM_SKID_EN
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t state, state_n;
  logic [PW-1:0] skid_q;
  logic ready_q, ld_skid, ld_from_skid;
  assign valid = state != EMPTY;
  assign ready_e_o = ready_q;
  assign occ_o = state == FULL ? 2'd2 : {1'b0, valid};
  always_comb begin
    state_n = state;
    ld_main = 1'b0;
    ld_skid = 1'b0;
    ld_from_skid = 1'b0;
    if (flush_i) state_n = EMPTY;
    else
      case (state)
        EMPTY: begin
          state_n = acc ? ONE : EMPTY;
          ld_main = acc;
        end
        ONE: begin
          state_n = acc && !dlv ? FULL : !acc && dlv ? EMPTY : ONE;
          ld_main = acc && dlv;
          ld_skid = acc && !dlv;
        end
        FULL: begin
          state_n = dlv ? ONE : FULL;
          ld_from_skid = dlv;
        end
        default: state_n = EMPTY;
      endcase
  end
  // ready is its own flop so the upstream never sees a path from ready_m_i
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state <= EMPTY;
      ready_q <= 1'b1;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state <= state_n;
      ready_q <= state_n != FULL;
      if (flush_i) main_q[CTRLW-1:0] <= '0;
      else if (ld_main) main_q <= in_p;
      else if (ld_from_skid) main_q <= skid_q;
      if (ld_skid) skid_q <= in_p;
    end
`else
  typedef enum logic {EMPTY, ONE} state_t;
  state_t state, state_n;
  assign valid = state != EMPTY;
  assign ready_e_o = !valid || ready_m_i;
  assign occ_o = {1'b0, valid};
  always_comb begin
    state_n = flush_i ? EMPTY : acc ? ONE : dlv ? EMPTY : state;
    ld_main = acc && !flush_i;
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state <= EMPTY;
      main_q <= '0;
    end else begin
      state <= state_n;
      if (flush_i) main_q[CTRLW-1:0] <= '0;
      else if (ld_main) main_q <= in_p;
    end
`endif
endmodule

// File: tb/tb_ex_mem_elastic_reg.sv
// tb_ex_mem_elastic_reg: random and directed traffic checked against a queue model of held entries.
`timescale 1ns/1ps
module tb_ex_mem_elastic_reg;
  typedef struct packed {
    logic [31:0] alu, wd, pc;
    logic [4:0]  rd;
    logic [13:0] ctrl;
  } ent_t;

  logic clk = 0, rst_i = 1, flush_i = 0, valid_e_i = 0, ready_m_i = 0;
  logic ready_e_o, valid_m_o;
  logic [31:0] alu_out_e = 0, write_data_e = 0, pc_plus_4_e = 0;
  logic [31:0] alu_out_m, write_data_m, pc_plus_4_m;
  logic [4:0] rd_e = 0, rd_m;
  logic [13:0] ctrl_e = 0, ctrl_m;
  logic [1:0] occ_o;
  int n_vec = 0, n_err = 0;
  ent_t sb[$];
  ent_t held;
  logic hold_chk = 0;

  always #5 clk = ~clk;

  ex_mem_elastic_reg dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .valid_e_i(valid_e_i), .ready_e_o(ready_e_o),
    .alu_out_e(alu_out_e), .write_data_e(write_data_e), .rd_e(rd_e),
    .pc_plus_4_e(pc_plus_4_e), .ctrl_e(ctrl_e),
    .valid_m_o(valid_m_o), .ready_m_i(ready_m_i),
    .alu_out_m(alu_out_m), .write_data_m(write_data_m), .pc_plus_4_m(pc_plus_4_m),
    .rd_m(rd_m), .ctrl_m(ctrl_m), .occ_o(occ_o)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic ent_t out_ent();
    return '{alu_out_m, write_data_m, pc_plus_4_m, rd_m, ctrl_m};
  endfunction

  task automatic drive(input logic v, input logic [31:0] alu, input logic [4:0] rd, input logic rdy, input logic fl);
    @(negedge clk);
    valid_e_i = v; alu_out_e = alu; rd_e = rd; ready_m_i = rdy; flush_i = fl;
    write_data_e = $urandom; pc_plus_4_e = $urandom; ctrl_e = 14'($urandom);
  endtask

  // Model side: record what the stage accepted, just before each edge.
  initial forever begin
    @(posedge clk); #9;
    begin
      logic a, f, r;
      ent_t e;
      a = valid_e_i && ready_e_o; f = flush_i; r = rst_i;
      e = '{alu_out_e, write_data_e, pc_plus_4_e, rd_e, ctrl_e};
      #0.5;
      if (r || f) sb.delete();
      else if (a) sb.push_back(e);
    end
  end

  // Monitor side: compare what the stage presents against the model.
  initial forever begin
    @(posedge clk); #9;
    if (!rst_i) begin
      chk("valid", 128'(valid_m_o), 128'(sb.size() != 0));
      chk("occ", 128'(occ_o), 128'(sb.size()));
`ifdef EX_MEM_SKID_EN
      chk("ready", 128'(ready_e_o), 128'(sb.size() < 2));
`else
      chk("ready", 128'(ready_e_o), 128'(sb.size() == 0 || ready_m_i));
`endif
      if (!valid_m_o) chk("ctrl_idle", 128'(ctrl_m), 128'(0));
      if (hold_chk) chk("hold", 128'(out_ent()), 128'(held));
      if (valid_m_o && ready_m_i && !flush_i) begin
        if (sb.size() == 0) chk("spurious_delivery", 128'(out_ent()), 128'(0));
        else chk("data", 128'(out_ent()), 128'(sb.pop_front()));
      end
      hold_chk = valid_m_o && !ready_m_i && !flush_i;
      held = out_ent();
    end else hold_chk = 0;
  end

  initial begin
    #2;
    chk("rst_valid", 128'(valid_m_o), 128'(0));
    chk("rst_ready", 128'(ready_e_o), 128'(1));
    chk("rst_occ", 128'(occ_o), 128'(0));
    chk("rst_payload", 128'(out_ent()), 128'(0));
    @(negedge clk); @(negedge clk); rst_i = 0;
    // streaming
    for (int i = 1; i <= 4; i++) drive(1, 32'(i * 16), 5'(i), 1, 0);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);
    // backpressure
    drive(1, 32'hA, 1, 0, 0);
    drive(1, 32'hB, 2, 0, 0);
    drive(0, 0, 0, 0, 0);
    #1;
    chk("bp_alu", 128'(alu_out_m), 128'(32'hA));
`ifdef EX_MEM_SKID_EN
    chk("bp_occ", 128'(occ_o), 128'(2));
    chk("bp_ready", 128'(ready_e_o), 128'(0));
`else
    chk("bp_occ", 128'(occ_o), 128'(1));
`endif
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 0);
    // flush while holding entries and offering rd=7
    drive(1, 32'hC, 3, 0, 0);
    drive(1, 32'hD, 4, 0, 0);
    drive(1, 32'hE, 7, 0, 1);
    drive(0, 0, 0, 1, 0);
    #1;
    chk("flush_valid", 128'(valid_m_o), 128'(0));
    chk("flush_ctrl", 128'(ctrl_m), 128'(0));
    chk("flush_occ", 128'(occ_o), 128'(0));
    drive(0, 0, 0, 1, 0);
    // async reset mid-cycle
    drive(1, 32'h1, 1, 0, 0);
    drive(1, 32'h2, 2, 0, 0);
    @(negedge clk); valid_e_i = 0;
    #2 rst_i = 1;
    #1;
    chk("arst_valid", 128'(valid_m_o), 128'(0));
    chk("arst_ready", 128'(ready_e_o), 128'(1));
    chk("arst_occ", 128'(occ_o), 128'(0));
    chk("arst_alu", 128'(alu_out_m), 128'(0));
    @(negedge clk); rst_i = 0;
    drive(1, 32'h55, 5, 0, 0);
    drive(0, 0, 0, 0, 0);
    #1;
    chk("post_rst_valid", 128'(valid_m_o), 128'(1));
    chk("post_rst_alu", 128'(alu_out_m), 128'(32'h55));
    drive(0, 0, 0, 1, 0);
    // ready toggling 1,0,1 with continuous valid
    drive(1, 32'h61, 1, 1, 0);
    drive(1, 32'h62, 2, 0, 0);
    drive(1, 32'h63, 3, 1, 0);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);
    // random traffic
    for (int i = 0; i < 15000; i++)
      drive(($urandom % 4) != 0, $urandom, 5'($urandom), ($urandom % 3) != 0, ($urandom % 64) == 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 1, 0);
    chk("drained", 128'(sb.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
